// File: rtl/mux_bus_pkg.sv
// Shared types and default constants for the multiplexed-bus line master.
package mux_bus_pkg;

  localparam int DEF_NCH         = 2;
  localparam int DEF_LINE_W      = 256;
  localparam int DEF_BUS_W       = 64;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int ADDR_W          = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WRESP = 3'd3,
    RDATA = 3'd4
  } state_t;

  // Index width for a channel count; never below one bit so ports stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last granted
// channel, pointer moves only when a grant is actually taken.
module rr_arbiter
  import mux_bus_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  localparam int IDX_W = idx_width(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic             en,
  output logic [NCH-1:0]   grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] last_r;
  logic [IDX_W-1:0] cand_s;
  logic             found_s;

  // Pick the first requesting channel after the last granted one.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    cand_s    = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand_s = IDX_W'((int'(last_r) + i) % NCH);
      if (!found_s && req[cand_s]) begin
        found_s       = 1'b1;
        grant[cand_s] = 1'b1;
        grant_idx     = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Remember the granted channel; reset makes channel 0 the next winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= IDX_W'(NCH - 1);
    end else if (en && (|req)) begin
      last_r <= grant_idx;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/mux_bus_master.sv
// Line-transfer master: arbitrates NCH requesters and moves whole lines over
// a narrow multiplexed address/data bus, least-significant beat first.
module mux_bus_master
  import mux_bus_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int LINE_W      = DEF_LINE_W,
  parameter int BUS_W       = DEF_BUS_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NCH-1:0]                 req_valid,
  input  logic [NCH-1:0]                 req_we,
  input  logic [NCH-1:0][ADDR_W-1:0]     req_addr,
  input  logic [NCH-1:0][LINE_W-1:0]     req_wdata,
  output logic [NCH-1:0]                 req_ready,
  output logic [NCH-1:0]                 done,
  output logic [NCH-1:0]                 err,
  output logic [LINE_W-1:0]              rdata,
  output logic [BUS_W-1:0]               address_data_bus_c_to_m,
  output logic                           address_on_c_to_m,
  output logic                           data_on_c_to_m,
  output logic                           read_en_c_to_m,
  output logic                           write_en_c_to_m,
  input  logic [BUS_W-1:0]               address_data_bus_m_to_c,
  input  logic                           data_on_m_to_c,
  input  logic                           resp_m_to_c
);

  localparam int BEATS = LINE_W / BUS_W;
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int IDX_W = idx_width(NCH);

  state_t             state_r;
  logic [NCH-1:0]     gnt_r;
  logic               we_r;
  logic [LINE_W-1:0]  wline_r;
  logic [CNT_W-1:0]   beat_r;
  logic [TMO_W-1:0]   tmo_r;

  logic [NCH-1:0]     grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic [ADDR_W-1:0]  line_addr_s;
  logic               arb_en_s;

  assign arb_en_s = (state_r == IDLE);

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (arb_en_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // Line-aligned address of the winning requester (offset-within-line cleared).
  always_comb begin
    line_addr_s = req_addr[grant_idx_s] & ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
  end

  // Transfer sequencer; every output is registered here so the bus is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r                 <= IDLE;
      gnt_r                   <= '0;
      we_r                    <= 1'b0;
      wline_r                 <= '0;
      beat_r                  <= '0;
      tmo_r                   <= '0;
      req_ready               <= '0;
      done                    <= '0;
      err                     <= '0;
      rdata                   <= '0;
      address_data_bus_c_to_m <= '0;
      address_on_c_to_m       <= 1'b0;
      data_on_c_to_m          <= 1'b0;
      read_en_c_to_m          <= 1'b0;
      write_en_c_to_m         <= 1'b0;
    end else begin
      req_ready <= '0;
      done      <= '0;
      err       <= '0;
      case (state_r)
        IDLE: begin
          if (|req_valid) begin
            req_ready               <= grant_s;
            gnt_r                   <= grant_s;
            we_r                    <= req_we[grant_idx_s];
            wline_r                 <= req_wdata[grant_idx_s];
            address_data_bus_c_to_m <= BUS_W'(line_addr_s);
            address_on_c_to_m       <= 1'b1;
            data_on_c_to_m          <= 1'b0;
            read_en_c_to_m          <= ~req_we[grant_idx_s];
            write_en_c_to_m         <= req_we[grant_idx_s];
            state_r                 <= ADDR;
          end else begin
            address_data_bus_c_to_m <= '0;
            address_on_c_to_m       <= 1'b0;
            data_on_c_to_m          <= 1'b0;
            read_en_c_to_m          <= 1'b0;
            write_en_c_to_m         <= 1'b0;
          end
        end
        ADDR: begin
          address_on_c_to_m <= 1'b0;
          read_en_c_to_m    <= 1'b0;
          write_en_c_to_m   <= 1'b0;
          tmo_r             <= '0;
          if (we_r) begin
            data_on_c_to_m          <= 1'b1;
            address_data_bus_c_to_m <= wline_r[BUS_W-1:0];
            beat_r                  <= CNT_W'(1);
            state_r                 <= WDATA;
          end else begin
            data_on_c_to_m          <= 1'b0;
            address_data_bus_c_to_m <= '0;
            beat_r                  <= '0;
            state_r                 <= RDATA;
          end
        end
        WDATA: begin
          if (beat_r == CNT_W'(BEATS)) begin
            data_on_c_to_m          <= 1'b0;
            address_data_bus_c_to_m <= '0;
            beat_r                  <= '0;
            tmo_r                   <= '0;
            state_r                 <= WRESP;
          end else begin
            address_data_bus_c_to_m <= wline_r[beat_r*BUS_W +: BUS_W];
            beat_r                  <= beat_r + CNT_W'(1);
          end
        end
        WRESP: begin
          if (resp_m_to_c) begin
            done    <= gnt_r;
            state_r <= IDLE;
          end else if (tmo_r == TMO_W'(TIMEOUT_CYC - 1)) begin
            done    <= gnt_r;
            err     <= gnt_r;
            tmo_r   <= '0;
            state_r <= IDLE;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        RDATA: begin
          if (data_on_m_to_c) begin
            rdata[beat_r*BUS_W +: BUS_W] <= address_data_bus_m_to_c;
            tmo_r                        <= '0;
            if (beat_r == CNT_W'(BEATS - 1)) begin
              done    <= gnt_r;
              beat_r  <= '0;
              state_r <= IDLE;
            end else begin
              beat_r <= beat_r + CNT_W'(1);
            end
          end else if (tmo_r == TMO_W'(TIMEOUT_CYC - 1)) begin
            done    <= gnt_r;
            err     <= gnt_r;
            tmo_r   <= '0;
            beat_r  <= '0;
            state_r <= IDLE;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        default: begin
          address_data_bus_c_to_m <= '0;
          address_on_c_to_m       <= 1'b0;
          data_on_c_to_m          <= 1'b0;
          read_en_c_to_m          <= 1'b0;
          write_en_c_to_m         <= 1'b0;
          state_r                 <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_bus_master.md
MUX_BUS_MASTER -- requirements
Module: mux_bus_master

Interface
REQ-001 SHALL have parameter NCH, default 2, number of requester channels (1..8).
REQ-002 SHALL have parameter LINE_W, default 256, line width in bits; must be a multiple of BUS_W.
REQ-003 SHALL have parameter BUS_W, default 64, width of the multiplexed address/data bus (>=32).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, cycles without memory progress before abort.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req_valid, input, NCH, per-channel request pending.
REQ-008 SHALL have port req_we, input, NCH, per-channel 1=write, 0=read.
REQ-009 SHALL have port req_addr, input, NCHx32, per-channel byte address.
REQ-010 SHALL have port req_wdata, input, NCHxLINE_W, per-channel write line.
REQ-011 SHALL have port req_ready, output, NCH, one-hot single-cycle accept pulse.
REQ-012 SHALL have port done, output, NCH, one-hot single-cycle completion pulse.
REQ-013 SHALL have port err, output, NCH, timeout flag, valid with done.
REQ-014 SHALL have port rdata, output, LINE_W, read line, valid while done is high.
REQ-015 SHALL have ports address_data_bus_c_to_m (BUS_W), address_on_c_to_m, data_on_c_to_m, read_en_c_to_m and write_en_c_to_m as outputs, the controller-to-memory bus.
REQ-016 SHALL have ports address_data_bus_m_to_c (BUS_W), data_on_m_to_c and resp_m_to_c as inputs, the memory-to-controller bus.

Function
REQ-017 SHALL define BEATS = LINE_W/BUS_W and transfer beats least-significant first.
REQ-018 SHALL implement states IDLE, ADDR, WDATA, WRESP and RDATA.
REQ-019 SHALL, in IDLE with any req_valid set, grant one channel round-robin starting after the last granted channel, pulse its req_ready, capture addr/we/wdata, and go to ADDR next cycle.
REQ-020 SHALL, in ADDR for exactly one cycle, drive address_on_c_to_m=1, read_en_c_to_m=~we, write_en_c_to_m=we, and the bus = zero-extended {addr[31:log2(LINE_W/8)], zeros}.
REQ-021 SHALL go from ADDR to WDATA on a write and to RDATA on a read.
REQ-022 SHALL, in WDATA, drive data_on_c_to_m=1 and one beat per cycle for BEATS consecutive cycles, then go to WRESP.
REQ-023 SHALL, in WRESP, wait for resp_m_to_c=1, then pulse done for the granted channel with err=0 and return to IDLE.
REQ-024 SHALL, in RDATA, capture address_data_bus_m_to_c into the next beat slot on each cycle with data_on_m_to_c=1 (gaps allowed); after the BEATS-th beat, pulse done with rdata valid in the following cycle, then return to IDLE.
REQ-025 SHALL hold a progress counter that clears on entering WRESP/RDATA and on each received beat; on reaching TIMEOUT_CYC it SHALL pulse done and err, leave rdata undefined, and return to IDLE.
REQ-026 SHALL ignore data_on_m_to_c outside RDATA and resp_m_to_c outside WRESP.
REQ-027 SHALL drive all c_to_m outputs to 0 whenever not in ADDR/WDATA.
REQ-028 SHALL NOT grant a new request in the same cycle that done pulses; the earliest re-grant is the next cycle.
REQ-029 SHALL treat req_valid deasserting after the grant as having no effect on the transfer.

Reset
REQ-030 SHALL, on rst, enter IDLE, zero all outputs, beat and timeout counters, and set the round-robin pointer so channel 0 has top priority.
REQ-031 SHALL, on rst mid-transfer, abandon the transfer without a done pulse and discard partial data.

Structure
REQ-032 SHALL place the state enum and default parameter constants in package mux_bus_pkg.
REQ-033 SHALL instantiate one sub-module, rr_arbiter (NCH-wide, round-robin, one-hot grant, pointer advanced on grant).

Verification (NCH=2, LINE_W=256, BUS_W=64, TIMEOUT_CYC=16)
REQ-034 SHALL test a channel-0 read of 0x0000_1234 -> address beat 0x0000_0000_0000_1220; memory returns beats 1,2,3,4 with one-cycle gaps -> done[0], rdata = {4,3,2,1}.
REQ-035 SHALL test a channel-1 write of line 0xDDDD..CCCC..BBBB..AAAA -> four consecutive data beats, with AAAA first; resp after 3 cycles -> done[1], err=0.
REQ-036 SHALL test both channels requesting every cycle for 4 transfers -> grants 0,1,0,1.
REQ-037 SHALL test a read answered with only 2 beats -> done[0] and err[0] exactly 16 cycles after the last beat.
REQ-038 SHALL test rst asserted during WDATA beat 2 -> all outputs 0 next cycle, no done; a subsequent read completes normally.
REQ-039 SHALL test spurious data_on_m_to_c and resp_m_to_c during IDLE -> no state change and no done.
